// File: rtl/device_scheduler.sv
// device_scheduler: three-requester, bank-matching scheduler for one device
// port. Tracks outstanding reads in an in-order tag queue so each i_ack is
// routed back to the requester that issued the read.
// Ports: requester side i_request/i_write/i_bank/i_address/i_data in,
//   o_busy/o_ack/o_data out. Device side o_request/o_write/o_address/
//   o_dev_data out, i_busy/i_ack/i_dev_data in. o_error is sticky and is set
//   by an ack that arrives with no read outstanding.
// Macro DEVICE_SCHEDULER_ROUND_ROBIN_EN: round-robin scan from a rotating
//   pointer. When it is undefined, priority is fixed at 0 > 1 > 2.
module device_scheduler #(
  parameter logic [3:0] DEVICE_BANK = 4'd0,
  parameter int         TAG_DEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_request,
  input  logic [2:0]  i_write,
  input  logic [11:0] i_bank,
  input  logic [77:0] i_address,
  input  logic [95:0] i_data,
  output logic [2:0]  o_busy,
  output logic [2:0]  o_ack,
  output logic [31:0] o_data,
  output logic        o_request,
  output logic        o_write,
  input  logic        i_busy,
  input  logic        i_ack,
  output logic [25:0] o_address,
  input  logic [31:0] i_dev_data,
  output logic [31:0] o_dev_data,
  output logic        o_error
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    match;
  logic [2:0]    eligible;
  logic          full;
  logic          empty;
  logic          found;
  logic          accept;
  logic          push;
  logic          pop;
  logic [1:0]    gnt;
  logic [1:0]    start;
  logic [1:0]    o1;
  logic [1:0]    o2;
  logic [1:0]    head;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    tags [TAG_DEPTH];

  function automatic logic [1:0] nxt(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

`ifdef DEVICE_SCHEDULER_ROUND_ROBIN_EN
  logic [1:0] ptr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr <= 2'd0;
    end else if (accept) begin
      ptr <= nxt(gnt);
    end
  end

  assign start = ptr;
`else
  assign start = 2'd0;
`endif

  // Full uses the registered count only, so a pop in the same cycle
  // does not make a read eligible.
  assign full  = (count == CW'(TAG_DEPTH));
  assign empty = (count == '0);

  always_comb begin
    match    = 3'b000;
    eligible = 3'b000;
    for (int k = 0; k < 3; k++) begin
      match[k]    = i_request[k] && (i_bank[4*k +: 4] == DEVICE_BANK);
      eligible[k] = match[k] && (i_write[k] || !full);
    end
  end

  assign o1 = nxt(start);
  assign o2 = nxt(o1);

  always_comb begin
    found = 1'b1;
    gnt   = 2'd0;
    if (eligible[start]) begin
      gnt = start;
    end else if (eligible[o1]) begin
      gnt = o1;
    end else if (eligible[o2]) begin
      gnt = o2;
    end else begin
      found = 1'b0;
    end
  end

  assign o_request = found && !i_reset;
  assign accept    = o_request && !i_busy;

  always_comb begin
    o_write    = 1'b0;
    o_address  = 26'd0;
    o_dev_data = 32'd0;
    if (found) begin
      case (gnt)
        2'd0: begin
          o_write    = i_write[0];
          o_address  = i_address[25:0];
          o_dev_data = i_data[31:0];
        end
        2'd1: begin
          o_write    = i_write[1];
          o_address  = i_address[51:26];
          o_dev_data = i_data[63:32];
        end
        default: begin
          o_write    = i_write[2];
          o_address  = i_address[77:52];
          o_dev_data = i_data[95:64];
        end
      endcase
    end
  end

  always_comb begin
    o_busy = 3'b000;
    for (int k = 0; k < 3; k++) begin
      o_busy[k] = match[k] && !(accept && gnt == 2'(k));
    end
  end

  assign push   = accept && !o_write;
  assign pop    = i_ack && !empty && !i_reset;
  assign head   = tags[rd_ptr];
  assign o_ack  = pop ? (3'b001 << head) : 3'b000;
  assign o_data = i_dev_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_error <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (i_ack && empty) begin
        o_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      tags[wr_ptr] <= gnt;
    end
  end

endmodule

// File: tb/tb_device_scheduler.sv
// tb_device_scheduler: directed and randomized checks of device_scheduler
// against a queue-based reference model of the scheduling rules.
module tb_device_scheduler;

  localparam logic [3:0] BANK  = 4'd2;
  localparam int         DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  wr;
  logic [11:0] bank;
  logic [77:0] addr;
  logic [95:0] wdata;
  logic        dbusy;
  logic        ack;
  logic [31:0] ddata;

  logic [2:0]  o_busy;
  logic [2:0]  o_ack;
  logic [31:0] o_data;
  logic        o_request;
  logic        o_write;
  logic [25:0] o_address;
  logic [31:0] o_dev_data;
  logic        o_error;

  int vectors;
  int errors;

  int q[$];
  int mptr;
  bit merr;

  int          e_g;
  bit          e_acc;
  logic        e_req;
  logic [2:0]  e_busy;
  logic [2:0]  e_ack;
  logic        e_wr;
  logic [25:0] e_addr;
  logic [31:0] e_wd;
  logic [2:0]  e_match;

  device_scheduler #(
    .DEVICE_BANK(BANK),
    .TAG_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_request(req),
    .i_write(wr),
    .i_bank(bank),
    .i_address(addr),
    .i_data(wdata),
    .o_busy(o_busy),
    .o_ack(o_ack),
    .o_data(o_data),
    .o_request(o_request),
    .o_write(o_write),
    .i_busy(dbusy),
    .i_ack(ack),
    .o_address(o_address),
    .i_dev_data(ddata),
    .o_dev_data(o_dev_data),
    .o_error(o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic calc();
    logic [2:0] el;
    int start;
    int k;
    e_g = -1;
    for (int i = 0; i < 3; i++) begin
      e_match[i] = req[i] && (bank[4*i +: 4] == BANK);
      el[i] = e_match[i] && (wr[i] || q.size() < DEPTH);
    end
`ifdef DEVICE_SCHEDULER_ROUND_ROBIN_EN
    start = mptr;
`else
    start = 0;
`endif
    for (int i = 0; i < 3; i++) begin
      k = (start + i) % 3;
      if (e_g < 0 && el[k]) e_g = k;
    end
    e_req = (e_g >= 0) && !rst;
    e_acc = e_req && !dbusy;
    e_wr = 1'b0;
    e_addr = 26'd0;
    e_wd = 32'd0;
    if (e_g >= 0) begin
      e_wr = wr[e_g];
      e_addr = addr[26*e_g +: 26];
      e_wd = wdata[32*e_g +: 32];
    end
    for (int i = 0; i < 3; i++)
      e_busy[i] = e_match[i] && !(e_acc && e_g == i);
    e_ack = 3'b000;
    if (ack && q.size() > 0 && !rst) e_ack[q[0]] = 1'b1;
  endtask

  task automatic tick();
    calc();
    @(posedge clk);
    if (rst) begin
      q.delete();
      mptr = 0;
      merr = 0;
    end else begin
      if (ack) begin
        if (q.size() > 0) void'(q.pop_front());
        else merr = 1;
      end
      if (e_acc) begin
        mptr = (e_g + 1) % 3;
        if (!wr[e_g]) q.push_back(e_g);
      end
    end
    #1;
  endtask

  task automatic idle();
    req = 3'b000;
    wr = 3'b000;
    bank = {3{BANK}};
    dbusy = 1'b0;
    ack = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    req = 3'b101;
    bank = {BANK, BANK + 4'd1, BANK};
    addr = 78'h123;
    wdata = 96'h0;
    ddata = 32'h0;
    #1;
    vectors++;
    if (o_request !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got %b want 0", o_request);
    end
    vectors++;
    if (o_busy !== 3'b101) begin
      errors++;
      $display("FAIL rst_busy got %b want 101", o_busy);
    end
    ack = 1'b1;
    #1;
    vectors++;
    if (o_ack !== 3'b000) begin
      errors++;
      $display("FAIL rst_ack got %b want 000", o_ack);
    end
    tick();
    tick();
    rst = 1'b0;
    idle();
    #1;
    vectors++;
    if (o_error !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got %b want 0", o_error);
    end
    vectors++;
    if (o_ack !== 3'b000 || o_request !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got ack=%b req=%b want 000/0",
               o_ack, o_request);
    end
  endtask

  task automatic test_two_reads();
    idle();
    req = 3'b011;
    addr = {26'h0, 26'h2AA, 26'h155};
    #1;
    vectors++;
    if (o_busy !== 3'b010 || o_address !== 26'h155) begin
      errors++;
      $display("FAIL two_c1 got busy=%b addr=%h want 010/155",
               o_busy, o_address);
    end
    tick();
    req = 3'b010;
    #1;
    vectors++;
    if (o_busy !== 3'b000 || o_address !== 26'h2AA) begin
      errors++;
      $display("FAIL two_c2 got busy=%b addr=%h want 000/2aa",
               o_busy, o_address);
    end
    tick();
    idle();
    tick();
    ack = 1'b1;
    ddata = 32'hDEAD_0001;
    #1;
    vectors++;
    if (o_ack !== 3'b001 || o_data !== 32'hDEAD_0001) begin
      errors++;
      $display("FAIL two_ack0 got %b/%h want 001/dead0001", o_ack, o_data);
    end
    tick();
    #1;
    vectors++;
    if (o_ack !== 3'b010) begin
      errors++;
      $display("FAIL two_ack1 got %b want 010", o_ack);
    end
    tick();
    idle();
  endtask

  task automatic test_bank();
    idle();
    req = 3'b010;
    bank[7:4] = BANK + 4'd1;
    #1;
    vectors++;
    if (o_request !== 1'b0 || o_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL bank got req=%b busy1=%b want 0/0",
               o_request, o_busy[1]);
    end
    tick();
    idle();
  endtask

  task automatic test_all_writes();
    int cnt[3];
    int g;
    idle();
    req = 3'b111;
    wr = 3'b111;
    cnt = '{0, 0, 0};
    for (int c = 0; c < 6; c++) begin
      #1;
      calc();
      g = -1;
      for (int i = 0; i < 3; i++) if (!o_busy[i]) g = i;
      vectors++;
      if (o_busy !== e_busy || g !== e_g) begin
        errors++;
        $display("FAIL writes_grant c=%0d got busy=%b g=%0d want %b g=%0d",
                 c, o_busy, g, e_busy, e_g);
      end
      if (g >= 0) cnt[g]++;
      tick();
    end
`ifdef DEVICE_SCHEDULER_ROUND_ROBIN_EN
    vectors++;
    if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2) begin
      errors++;
      $display("FAIL rr_share got %0d/%0d/%0d want 2/2/2",
               cnt[0], cnt[1], cnt[2]);
    end
`else
    req = 3'b110;
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if (o_busy !== 3'b100) begin
        errors++;
        $display("FAIL fixed_prio got %b want 100", o_busy);
      end
      tick();
    end
`endif
    idle();
  endtask

  task automatic test_full();
    idle();
    req = 3'b100;
    for (int c = 0; c < DEPTH; c++) begin
      #1;
      vectors++;
      if (o_busy[2] !== 1'b0) begin
        errors++;
        $display("FAIL full_fill c=%0d got busy2=%b want 0", c, o_busy[2]);
      end
      tick();
    end
    req = 3'b101;
    wr = 3'b001;
    #1;
    vectors++;
    if (o_busy !== 3'b100 || o_request !== 1'b1 || o_write !== 1'b1) begin
      errors++;
      $display("FAIL full_block got busy=%b req=%b wr=%b want 100/1/1",
               o_busy, o_request, o_write);
    end
    tick();
    req = 3'b100;
    wr = 3'b000;
    ack = 1'b1;
    #1;
    vectors++;
    if (o_ack !== 3'b100 || o_busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL full_pop got ack=%b busy2=%b want 100/1",
               o_ack, o_busy[2]);
    end
    tick();
    ack = 1'b0;
    #1;
    vectors++;
    if (o_busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL full_resume got busy2=%b want 0", o_busy[2]);
    end
    tick();
    idle();
    ack = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      #1;
      vectors++;
      if (o_ack !== 3'b100) begin
        errors++;
        $display("FAIL full_drain c=%0d got %b want 100", c, o_ack);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_spurious();
    idle();
    ack = 1'b1;
    #1;
    vectors++;
    if (o_ack !== 3'b000 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL spur_now got ack=%b err=%b want 000/0", o_ack, o_error);
    end
    tick();
    ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (o_error !== 1'b1) begin
        errors++;
        $display("FAIL spur_sticky c=%0d got %b want 1", c, o_error);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (o_error !== 1'b0) begin
      errors++;
      $display("FAIL spur_clear got %b want 0", o_error);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      req = 3'($urandom);
      wr = 3'($urandom);
      for (int i = 0; i < 3; i++)
        bank[4*i +: 4] = ($urandom_range(0, 4) == 0) ? BANK + 4'd1 : BANK;
      addr = {$urandom, $urandom, $urandom};
      wdata = {$urandom, $urandom, $urandom};
      dbusy = ($urandom_range(0, 3) == 0);
      ack = ($urandom_range(0, 2) == 0);
      ddata = $urandom;
      #1;
      calc();
      vectors++;
      if (o_request !== e_req || o_busy !== e_busy || o_ack !== e_ack) begin
        errors++;
        $display("FAIL rnd_ctl c=%0d got req=%b busy=%b ack=%b want %b %b %b",
                 c, o_request, o_busy, o_ack, e_req, e_busy, e_ack);
      end
      vectors++;
      if (o_write !== e_wr || o_address !== e_addr ||
          o_dev_data !== e_wd || o_data !== ddata) begin
        errors++;
        $display("FAIL rnd_dat c=%0d got %b %h %h %h want %b %h %h %h",
                 c, o_write, o_address, o_dev_data, o_data,
                 e_wr, e_addr, e_wd, ddata);
      end
      vectors++;
      if (o_error !== merr) begin
        errors++;
        $display("FAIL rnd_err c=%0d got %b want %b", c, o_error, merr);
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    vectors = 0;
    errors = 0;
    mptr = 0;
    merr = 0;
    rst = 1'b1;
    idle();
    addr = '0;
    wdata = '0;
    ddata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_two_reads();
    test_bank();
    test_all_writes();
    test_full();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
